// File: rtl/interdevice_tx_arbiter.sv
// interdevice_tx_arbiter: packet-granular round-robin sharing of the tx link.
// Optional stall watchdog enabled by defining INTERDEVICE_ARB_TIMEOUT_EN.
module interdevice_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int FLIT_WIDTH = 64,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] in_flit,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    output logic [FLIT_WIDTH-1:0]         out_flit,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int          PW   = $clog2(NUM_REQ);
    localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               hs;
    logic               expire;
    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    logic [PW:0]        cand;

    // Search from rr_ptr upward; wrap by explicit compare for non-pow2 counts
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!pick_found && in_valid[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = BUSY;
                    grant_d  = NUM_REQ'(1) << pick_idx;
                    rr_ptr_d = (pick_idx == PW'(NUM_REQ - 1)) ? '0
                                                              : pick_idx + PW'(1);
                end
            end
            BUSY: begin
                if ((hs && out_last) || expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    // grant_q is zero outside BUSY, so it alone gates the pass-through
    always_comb begin
        out_valid = 1'b0;
        out_flit  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                out_valid   = in_valid[i];
                out_flit    = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                out_last    = in_last[i];
                in_ready[i] = out_ready;
            end
        end
    end

    assign hs    = out_valid & out_ready;
    assign grant = grant_q;
    assign busy  = (state_q == BUSY);

`ifdef INTERDEVICE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_q, stall_d;
    logic          timeout_err_q;

    // Counts no-handshake BUSY cycles; zero whenever not BUSY
    always_comb begin
        stall_d = '0;
        expire  = 1'b0;
        if (state_q == BUSY && !hs) begin
            if (stall_q == CW'(TIMEOUT - 1)) begin
                expire = 1'b1;
            end else begin
                stall_d = stall_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            stall_q       <= stall_d;
            timeout_err_q <= expire;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_interdevice_tx_arbiter.sv
// Bench for interdevice_tx_arbiter: directed vector table, hand sequences
// and randomized traffic against a packet-level reference model.
module tb_interdevice_tx_arbiter;
    localparam int N  = 3;
    localparam int W  = 64;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_valid, in_last, in_ready, grant;
    logic [N*W-1:0] in_flit;
    logic           out_valid, out_last, out_ready, busy, timeout_err;
    logic [W-1:0]   out_flit;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    interdevice_tx_arbiter #(.NUM_REQ(N), .FLIT_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_flit(in_flit), .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last),
        .out_ready(out_ready),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [2:0] v;
        logic [2:0] l;
        logic       ord;
        logic [7:0] d0, d1, d2;
        logic [2:0] eg;
        logic       eov;
        logic [2:0] eir;
        logic [7:0] ef;
        logic       eol;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] v, input logic [2:0] l, input logic ord,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [2:0] eg, input logic eov, input logic [2:0] eir,
                       input logic [7:0] ef, input logic eol);
        vec_t t;
        t.v = v; t.l = l; t.ord = ord;
        t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.eg = eg; t.eov = eov; t.eir = eir; t.ef = ef; t.eol = eol;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic ord,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        in_valid  = v;
        in_last   = l;
        out_ready = ord;
        in_flit   = {64'(d2), 64'(d1), 64'(d0)};
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " grant"}, 64'(grant), 64'd0);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " out_flit"}, out_flit, 64'd0);
        chk({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Packet-level reference: owner index or -1, next search start, stall count
    int   m_owner, m_next, m_stall;
    logic m_terr;

    task automatic model_reset();
        m_owner = -1;
        m_next  = 0;
        m_stall = 0;
        m_terr  = 1'b0;
    endtask

    task automatic rand_run(input int cycles);
        logic         ev, el, hs, terr_n;
        logic [W-1:0] ef;
        logic [N-1:0] eir, eg;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            in_valid = 3'($urandom_range(0, 7));
            for (int r = 0; r < N; r++) in_last[r] = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2 * N; r++) in_flit[r*32 +: 32] = $urandom;
            #1;
            ev = 1'b0; el = 1'b0; ef = '0; eir = '0; eg = '0;
            if (m_owner >= 0) begin
                ev  = in_valid[m_owner];
                el  = in_last[m_owner];
                ef  = in_flit[m_owner*W +: W];
                eg  = 3'(1 << m_owner);
                eir = out_ready ? eg : 3'b000;
            end
            chk($sformatf("rnd%0d grant", c), 64'(grant), 64'(eg));
            chk($sformatf("rnd%0d out_valid", c), 64'(out_valid), 64'(ev));
            chk($sformatf("rnd%0d in_ready", c), 64'(in_ready), 64'(eir));
            chk($sformatf("rnd%0d out_flit", c), out_flit, ef);
            chk($sformatf("rnd%0d out_last", c), 64'(out_last), 64'(el));
            chk($sformatf("rnd%0d busy", c), 64'(busy), 64'(m_owner >= 0));
            chk($sformatf("rnd%0d timeout_err", c), 64'(timeout_err), 64'(m_terr));
            terr_n = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && in_valid[(m_next + k) % N]) begin
                        m_owner = (m_next + k) % N;
                    end
                end
                if (m_owner >= 0) begin
                    m_next  = (m_owner + 1) % N;
                    m_stall = 0;
                end
            end else begin
                hs = ev && out_ready;
                if (hs) begin
                    m_stall = 0;
                    if (el) m_owner = -1;
                end else begin
                    m_stall++;
`ifdef INTERDEVICE_ARB_TIMEOUT_EN
                    if (m_stall == TO) begin
                        m_owner = -1;
                        terr_n  = 1'b1;
                    end
`endif
                end
            end
            m_terr = terr_n;
        end
    endtask

    initial begin
        drive(3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);
        // req0 alone, 4-flit packet
        add(3'b001, 3'b000, 1, 8'hA0, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b001, 3'b000, 1, 8'hA0, 0, 0, 3'b001, 1, 3'b001, 8'hA0, 0);
        add(3'b001, 3'b000, 1, 8'hA1, 0, 0, 3'b001, 1, 3'b001, 8'hA1, 0);
        add(3'b001, 3'b000, 1, 8'hA2, 0, 0, 3'b001, 1, 3'b001, 8'hA2, 0);
        add(3'b001, 3'b001, 1, 8'hA3, 0, 0, 3'b001, 1, 3'b001, 8'hA3, 1);
        add(3'b000, 3'b000, 1, 8'h00, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        // all valid, single-flit packets, rotation from rr_ptr=1
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b010, 1, 3'b010, 8'h11, 1);
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b100, 1, 3'b100, 8'h12, 1);
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b001, 1, 3'b001, 8'h10, 1);
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b111, 3'b111, 1, 8'h10, 8'h11, 8'h12, 3'b010, 1, 3'b010, 8'h11, 1);
        // req2 waits behind req0's 3-flit packet
        add(3'b001, 3'b000, 1, 8'hB0, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b101, 3'b100, 1, 8'hB0, 0, 8'hC0, 3'b001, 1, 3'b001, 8'hB0, 0);
        add(3'b101, 3'b100, 1, 8'hB1, 0, 8'hC0, 3'b001, 1, 3'b001, 8'hB1, 0);
        add(3'b101, 3'b101, 1, 8'hB2, 0, 8'hC0, 3'b001, 1, 3'b001, 8'hB2, 1);
        add(3'b100, 3'b100, 1, 8'h00, 0, 8'hC0, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b100, 3'b100, 1, 8'h00, 0, 8'hC0, 3'b100, 1, 3'b100, 8'hC0, 1);
        // back-pressure on req1 for 5 cycles
        add(3'b010, 3'b000, 1, 0, 8'hD0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b010, 3'b000, 1, 0, 8'hD0, 0, 3'b010, 1, 3'b010, 8'hD0, 0);
        for (int i = 0; i < 5; i++)
            add(3'b010, 3'b000, 0, 0, 8'hD1, 0, 3'b010, 1, 3'b000, 8'hD1, 0);
        add(3'b010, 3'b000, 1, 0, 8'hD1, 0, 3'b010, 1, 3'b010, 8'hD1, 0);
        add(3'b010, 3'b010, 1, 0, 8'hD2, 0, 3'b010, 1, 3'b010, 8'hD2, 1);
        // owner drops valid mid-packet: grant held
        add(3'b001, 3'b000, 1, 8'hE0, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
        add(3'b001, 3'b000, 1, 8'hE0, 0, 0, 3'b001, 1, 3'b001, 8'hE0, 0);
        add(3'b000, 3'b000, 1, 8'h00, 0, 0, 3'b001, 0, 3'b001, 8'h00, 0);
        add(3'b001, 3'b001, 1, 8'hE1, 0, 0, 3'b001, 1, 3'b001, 8'hE1, 1);
        add(3'b000, 3'b000, 1, 8'h00, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);

        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].l, tbl[i].ord, tbl[i].d0, tbl[i].d1, tbl[i].d2);
            #1;
            chk($sformatf("r%0d grant", i), 64'(grant), 64'(tbl[i].eg));
            chk($sformatf("r%0d out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
            chk($sformatf("r%0d in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
            chk($sformatf("r%0d out_flit", i), out_flit, 64'(tbl[i].ef));
            chk($sformatf("r%0d out_last", i), 64'(out_last), 64'(tbl[i].eol));
            chk($sformatf("r%0d busy", i), 64'(busy), 64'(tbl[i].eg != 3'b000));
            chk($sformatf("r%0d timeout_err", i), 64'(timeout_err), 64'd0);
        end

        // reset asserted mid-packet drops the grant at once
        @(negedge clk);
        drive(3'b010, 3'b000, 1'b1, 8'h00, 8'hF0, 8'h00);
        @(negedge clk);
        #1;
        chk("midrst pre grant", 64'(grant), 64'(3'b010));
        rst_n = 1'b0;
        #1;
        chk("midrst grant", 64'(grant), 64'd0);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        @(negedge clk);
        drive(3'b000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

`ifdef INTERDEVICE_ARB_TIMEOUT_EN
        do_reset();
        @(negedge clk);
        drive(3'b011, 3'b000, 1'b1, 8'h50, 8'h60, 8'h00);
        @(negedge clk);
        #1;
        chk("to flit1 grant", 64'(grant), 64'(3'b001));
        chk("to flit1 out_valid", 64'(out_valid), 64'd1);
        for (int s = 1; s <= TO; s++) begin
            @(negedge clk);
            drive(3'b010, 3'b000, 1'b1, 8'h00, 8'h60, 8'h00);
            #1;
            chk($sformatf("to stall%0d grant", s), 64'(grant), 64'(3'b001));
            chk($sformatf("to stall%0d err", s), 64'(timeout_err), 64'd0);
        end
        @(negedge clk);
        #1;
        chk("to release err", 64'(timeout_err), 64'd1);
        chk("to release grant", 64'(grant), 64'd0);
        @(negedge clk);
        #1;
        chk("to next err", 64'(timeout_err), 64'd0);
        chk("to next grant", 64'(grant), 64'(3'b010));
`endif

        do_reset();
        model_reset();
        rand_run(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
